// File: rtl/prog_loader_ctrl_pkg.sv
// Shared encodings for the program loader: header field layout, target codes and FSM states.
// Defining PROG_LOADER_CSUM_EN adds the CSUM and ERROR states used by the checksum check.
package prog_loader_ctrl_pkg;

  localparam logic [1:0] TGT_NOP  = 2'b00;
  localparam logic [1:0] TGT_IMEM = 2'b01;
  localparam logic [1:0] TGT_DMEM = 2'b10;
  localparam logic [1:0] TGT_DONE = 2'b11;

  localparam int HDR_TGT_LSB   = 30;
  localparam int HDR_START_LSB = 16;
  localparam int HDR_COUNT_LSB = 0;
  localparam int START_W       = 14;
  localparam int COUNT_W       = 16;

  typedef struct packed {
    logic [1:0]         tgt;
    logic [START_W-1:0] start;
    logic [COUNT_W-1:0] count;
  } hdr_t;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_IMEM_PAY,
    ST_DMEM_PAY,
    ST_RELEASE,
    ST_RUN
`ifdef PROG_LOADER_CSUM_EN
    ,
    ST_CSUM,
    ST_ERROR
`endif
  } state_e;

  function automatic hdr_t decode_hdr(input logic [31:0] word);
    hdr_t h;
    h.tgt   = word[HDR_TGT_LSB +: 2];
    h.start = word[HDR_START_LSB +: START_W];
    h.count = word[HDR_COUNT_LSB +: COUNT_W];
    return h;
  endfunction

endpackage

// File: rtl/prog_line_packer.sv
// Packs 32-bit stream words MSB-first into 128-bit imem lines and emits one registered
// line write per full line, or early on the last word of a segment with unfilled lanes zero.
module prog_line_packer #(
  parameter int IMEM_AW = 9
) (
  input  logic               clk,
  input  logic               reset_x,
  input  logic               seg_start,
  input  logic [IMEM_AW-1:0] seg_line,
  input  logic               word_valid,
  input  logic               word_last,
  input  logic [31:0]        word,
  output logic               line_we,
  output logic [IMEM_AW-1:0] line_addr,
  output logic [127:0]       line_data
);

  logic [1:0]         lane_q, lane_d;
  logic [127:0]       buf_q, buf_d;
  logic [127:0]       merged;
  logic [IMEM_AW-1:0] line_q, line_d;
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [127:0]       data_q, data_d;

  always_comb begin
    merged = buf_q;
    case (lane_q)
      2'd0: merged[127:96] = word;
      2'd1: merged[95:64]  = word;
      2'd2: merged[63:32]  = word;
      2'd3: merged[31:0]   = word;
    endcase
  end

  always_comb begin
    lane_d = lane_q;
    buf_d  = buf_q;
    line_d = line_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (seg_start) begin
      line_d = seg_line;
      lane_d = '0;
      buf_d  = '0;
    end else if (word_valid) begin
      if (lane_q == 2'd3 || word_last) begin
        we_d   = 1'b1;
        addr_d = line_q;
        data_d = merged;
        line_d = line_q + IMEM_AW'(1);
        lane_d = '0;
        buf_d  = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        buf_d  = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      lane_q <= '0;
      buf_q  <= '0;
      line_q <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      lane_q <= lane_d;
      buf_q  <= buf_d;
      line_q <= line_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign line_we   = we_q;
  assign line_addr = addr_q;
  assign line_data = data_q;

endmodule

// File: rtl/prog_loader_ctrl.sv
// Boot loader: streams a header-framed image into imem/dmem, then releases core reset and
// hands dmem to the core. Define PROG_LOADER_CSUM_EN to verify a trailing image checksum.
module prog_loader_ctrl
  import prog_loader_ctrl_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int IMEM_AW  = 9,
  parameter int RST_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset_x,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_data,
  input  logic [ADDR_LEN-1:0] core_dmem_addr,
  input  logic [DATA_LEN-1:0] core_dmem_wdata,
  input  logic                core_dmem_we,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [DATA_LEN-1:0] dmem_wdata,
  output logic                dmem_we,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic [127:0]        imem_wdata,
  output logic                imem_we,
  output logic                core_reset,
  output logic                loaded
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_e               state_q, state_d;
  logic [START_W-1:0]   start_q, start_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0]   n_q, n_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 ld_we_q, ld_we_d;
  logic [ADDR_LEN-1:0]  ld_addr_q, ld_addr_d;
  logic [DATA_LEN-1:0]  ld_wdata_q, ld_wdata_d;
  logic                 core_reset_q, core_reset_d;
  logic                 loaded_q, loaded_d;
`ifdef PROG_LOADER_CSUM_EN
  logic [31:0]          sum_q, sum_d;
`endif

  hdr_t                 hdr;
  logic                 accept;
  logic                 last_word;
  logic [START_W-1:0]   dmem_idx;
  logic                 pk_start, pk_valid, pk_last;
  logic                 pk_we;
  logic [IMEM_AW-1:0]   pk_addr;
  logic [127:0]         pk_data;

  assign hdr       = decode_hdr(in_data);
  assign accept    = in_valid & in_ready;
  assign last_word = (cnt_q + 16'd1 == n_q);
  assign dmem_idx  = start_q + cnt_q[START_W-1:0];

  // Stream is only accepted while loading; reset gates it combinationally.
  always_comb begin
    in_ready = 1'b0;
    if (reset_x) begin
      case (state_q)
        ST_HDR, ST_IMEM_PAY, ST_DMEM_PAY: in_ready = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
        ST_CSUM:                          in_ready = 1'b1;
`endif
        default:                          in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    hold_d       = '0;
    ld_we_d      = 1'b0;
    ld_addr_d    = ld_addr_q;
    ld_wdata_d   = ld_wdata_q;
    core_reset_d = core_reset_q;
    loaded_d     = loaded_q;
    pk_start     = 1'b0;
    pk_valid     = 1'b0;
    pk_last      = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      ST_HDR: begin
        if (accept) begin
          start_d = hdr.start;
          n_d     = hdr.count;
          cnt_d   = '0;
          case (hdr.tgt)
            TGT_NOP:  state_d = ST_HDR;
            TGT_IMEM: begin
              if (hdr.count != '0) begin
                state_d  = ST_IMEM_PAY;
                pk_start = 1'b1;
              end
            end
            TGT_DMEM: begin
              if (hdr.count != '0) state_d = ST_DMEM_PAY;
            end
            TGT_DONE: begin
`ifdef PROG_LOADER_CSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_RELEASE;
`endif
            end
          endcase
        end
      end
      ST_IMEM_PAY: begin
        if (accept) begin
          pk_valid = 1'b1;
          pk_last  = last_word;
          cnt_d    = cnt_q + 16'd1;
`ifdef PROG_LOADER_CSUM_EN
          sum_d    = sum_q + in_data;
`endif
          if (last_word) state_d = ST_HDR;
        end
      end
      ST_DMEM_PAY: begin
        if (accept) begin
          ld_we_d    = 1'b1;
          ld_addr_d  = ADDR_LEN'({dmem_idx, 2'b00});
          ld_wdata_d = DATA_LEN'(in_data);
          cnt_d      = cnt_q + 16'd1;
`ifdef PROG_LOADER_CSUM_EN
          sum_d      = sum_q + in_data;
`endif
          if (last_word) state_d = ST_HDR;
        end
      end
      ST_RELEASE: begin
        if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d      = ST_RUN;
          core_reset_d = 1'b0;
          loaded_d     = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: state_d = ST_RUN;
`ifdef PROG_LOADER_CSUM_EN
      ST_CSUM: begin
        if (accept) state_d = (in_data == sum_q) ? ST_RELEASE : ST_ERROR;
      end
      ST_ERROR: state_d = ST_ERROR;
`endif
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state_q      <= ST_HDR;
      start_q      <= '0;
      cnt_q        <= '0;
      n_q          <= '0;
      hold_q       <= '0;
      ld_we_q      <= 1'b0;
      ld_addr_q    <= '0;
      ld_wdata_q   <= '0;
      core_reset_q <= 1'b1;
      loaded_q     <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      hold_q       <= hold_d;
      ld_we_q      <= ld_we_d;
      ld_addr_q    <= ld_addr_d;
      ld_wdata_q   <= ld_wdata_d;
      core_reset_q <= core_reset_d;
      loaded_q     <= loaded_d;
`ifdef PROG_LOADER_CSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  prog_line_packer #(
    .IMEM_AW (IMEM_AW)
  ) u_packer (
    .clk        (clk),
    .reset_x    (reset_x),
    .seg_start  (pk_start),
    .seg_line   (IMEM_AW'(hdr.start)),
    .word_valid (pk_valid),
    .word_last  (pk_last),
    .word       (in_data),
    .line_we    (pk_we),
    .line_addr  (pk_addr),
    .line_data  (pk_data)
  );

  // Once running, the core owns the dmem port outright.
  always_comb begin
    dmem_addr  = ld_addr_q;
    dmem_wdata = ld_wdata_q;
    dmem_we    = ld_we_q;
    if (state_q == ST_RUN) begin
      dmem_addr  = core_dmem_addr;
      dmem_wdata = core_dmem_wdata;
      dmem_we    = core_dmem_we;
    end
  end

  assign imem_we    = pk_we & (state_q != ST_RUN);
  assign imem_addr  = pk_addr;
  assign imem_wdata = pk_data;
  assign core_reset = core_reset_q;
  assign loaded     = loaded_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Self-checking bench for prog_loader_ctrl: directed images, a write-queue model and literal pins.
// Build with PROG_LOADER_CSUM_EN to exercise the checksum path.
module tb_prog_loader_ctrl;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;
  localparam int IMEM_AW  = 9;
  localparam int RST_HOLD = 4;
  localparam int INF      = 32'h7fff_ffff;

  logic                clk = 1'b0;
  logic                reset_x;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_data;
  logic [ADDR_LEN-1:0] core_dmem_addr;
  logic [DATA_LEN-1:0] core_dmem_wdata;
  logic                core_dmem_we;
  logic [ADDR_LEN-1:0] dmem_addr;
  logic [DATA_LEN-1:0] dmem_wdata;
  logic                dmem_we;
  logic [IMEM_AW-1:0]  imem_addr;
  logic [127:0]        imem_wdata;
  logic                imem_we;
  logic                core_reset;
  logic                loaded;

  typedef struct {int due; logic [IMEM_AW-1:0] addr; logic [127:0] data;} imem_exp_t;
  typedef struct {int due; logic [31:0] addr; logic [31:0] data;} dmem_exp_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          checking = 1'b0;
  int          done_cyc = INF;
  int          rel_cyc = INF;
  int          fall_cyc = -1;
  logic        prev_core_reset = 1'b1;
  logic [31:0] model_sum = '0;
  imem_exp_t   imem_q[$];
  dmem_exp_t   dmem_q[$];
  logic [IMEM_AW-1:0] ilog_addr[$];
  logic [127:0]       ilog_data[$];
  logic [31:0]        dlog_addr[$];
  logic [31:0]        dlog_data[$];
  logic [31:0]        pay[$];

  prog_loader_ctrl #(
    .ADDR_LEN (ADDR_LEN),
    .DATA_LEN (DATA_LEN),
    .IMEM_AW  (IMEM_AW),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk             (clk),
    .reset_x         (reset_x),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .core_dmem_addr  (core_dmem_addr),
    .core_dmem_wdata (core_dmem_wdata),
    .core_dmem_we    (core_dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_we         (dmem_we),
    .imem_addr       (imem_addr),
    .imem_wdata      (imem_wdata),
    .imem_we         (imem_we),
    .core_reset      (core_reset),
    .loaded          (loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic reportFail(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_errors++;
    $display("[TB] FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) reportFail(name, act, exp);
  endtask

  function automatic logic [127:0] ilogAt(input int i);
    return (i < ilog_data.size()) ? ilog_data[i] : 'x;
  endfunction

  function automatic logic [31:0] ilogAddrAt(input int i);
    return (i < ilog_addr.size()) ? 32'(ilog_addr[i]) : 'x;
  endfunction

  function automatic logic [31:0] dlogAddrAt(input int i);
    return (i < dlog_addr.size()) ? dlog_addr[i] : 'x;
  endfunction

  function automatic logic [31:0] dlogDataAt(input int i);
    return (i < dlog_data.size()) ? dlog_data[i] : 'x;
  endfunction

  // Compare process: outputs against the expected-write queues and release timing each cycle.
  always @(negedge clk) begin
    if (checking) begin
      bit ie, de, exp_rst;
      exp_rst = !(cyc >= rel_cyc);
      checkOutput("in_ready", in_ready, reset_x && (cyc < done_cyc));
      checkOutput("core_reset", core_reset, exp_rst);
      checkOutput("loaded", loaded, !exp_rst);
      if (prev_core_reset === 1'b1 && core_reset === 1'b0) fall_cyc = cyc;
      prev_core_reset = core_reset;

      while (imem_q.size() > 0 && imem_q[0].due < cyc) begin
        n_checks++;
        reportFail("imem_missed_write", 0, imem_q[0].data);
        void'(imem_q.pop_front());
      end
      ie = (imem_q.size() > 0) && (imem_q[0].due == cyc);
      checkOutput("imem_we", imem_we, ie);
      if (imem_we === 1'b1) begin
        ilog_addr.push_back(imem_addr);
        ilog_data.push_back(imem_wdata);
      end
      if (ie && imem_we === 1'b1) begin
        checkOutput("imem_addr", imem_addr, imem_q[0].addr);
        checkOutput("imem_wdata", imem_wdata, imem_q[0].data);
        void'(imem_q.pop_front());
      end

      if (cyc >= rel_cyc) begin
        checkOutput("run_dmem_addr", dmem_addr, core_dmem_addr);
        checkOutput("run_dmem_wdata", dmem_wdata, core_dmem_wdata);
        checkOutput("run_dmem_we", dmem_we, core_dmem_we);
      end else begin
        while (dmem_q.size() > 0 && dmem_q[0].due < cyc) begin
          n_checks++;
          reportFail("dmem_missed_write", 0, dmem_q[0].addr);
          void'(dmem_q.pop_front());
        end
        de = (dmem_q.size() > 0) && (dmem_q[0].due == cyc);
        checkOutput("dmem_we", dmem_we, de);
        if (dmem_we === 1'b1) begin
          dlog_addr.push_back(dmem_addr);
          dlog_data.push_back(dmem_wdata);
        end
        if (de && dmem_we === 1'b1) begin
          checkOutput("dmem_addr", dmem_addr, dmem_q[0].addr);
          checkOutput("dmem_wdata", dmem_wdata, dmem_q[0].data);
          void'(dmem_q.pop_front());
        end
      end
    end
  end

  // Drives one stream word for one cycle; core-side port carries junk that must be ignored.
  task automatic applyStimulus(input logic [31:0] w);
    in_valid        = 1'b1;
    in_data         = w;
    core_dmem_addr  = $urandom;
    core_dmem_wdata = $urandom;
    core_dmem_we    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic modelReset();
    imem_q.delete();
    dmem_q.delete();
    ilog_addr.delete();
    ilog_data.delete();
    dlog_addr.delete();
    dlog_data.delete();
    done_cyc  = INF;
    rel_cyc   = INF;
    fall_cyc  = -1;
    model_sum = '0;
  endtask

  task automatic resetDut();
    reset_x  = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    checking = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_x = 1'b1;
  endtask

  // Lines are built MSB-first from the payload; one expected write per full or final line.
  task automatic sendImem(input int start);
    int          n;
    int          base;
    logic [127:0] line;
    imem_exp_t   e;
    n = pay.size();
    applyStimulus({2'b01, 14'(start), 16'(n)});
    for (int k = 0; k < n; k++) begin
      if ((k % 4 == 3) || (k == n - 1)) begin
        base = k - (k % 4);
        line = '0;
        for (int j = 0; j <= k % 4; j++) line[127 - 32*j -: 32] = pay[base + j];
        e.due  = cyc + 1;
        e.addr = IMEM_AW'((start + k / 4) % (1 << IMEM_AW));
        e.data = line;
        imem_q.push_back(e);
      end
      model_sum += pay[k];
      applyStimulus(pay[k]);
    end
    in_valid = 1'b0;
  endtask

  task automatic sendDmem(input int start);
    int        n;
    dmem_exp_t e;
    n = pay.size();
    applyStimulus({2'b10, 14'(start), 16'(n)});
    for (int k = 0; k < n; k++) begin
      e.due  = cyc + 1;
      e.addr = 32'(((start + k) % 16384) * 4);
      e.data = pay[k];
      dmem_q.push_back(e);
      model_sum += pay[k];
      applyStimulus(pay[k]);
    end
    in_valid = 1'b0;
  endtask

  task automatic sendDone(input bit bad_sum);
    applyStimulus(32'hC000_0000);
`ifdef PROG_LOADER_CSUM_EN
    applyStimulus(model_sum + (bad_sum ? 32'd1 : 32'd0));
`endif
    done_cyc = cyc;
    rel_cyc  = bad_sum ? INF : cyc + RST_HOLD;
    in_valid = 1'b0;
  endtask

  task automatic runCore(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid        = 1'b1;
      in_data         = 32'h4000_0004;
      core_dmem_addr  = $urandom;
      core_dmem_wdata = $urandom;
      core_dmem_we    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    n_checks++;
    reportFail("watchdog_timeout", 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    reset_x         = 1'b0;
    in_valid        = 1'b0;
    in_data         = '0;
    core_dmem_addr  = '0;
    core_dmem_wdata = '0;
    core_dmem_we    = 1'b0;
    #1;

    $display("[TB] reset and idle");
    resetDut();
    idle(100);
    checkOutput("idle_no_writes", 32'(ilog_data.size() + dlog_data.size()), 0);

    $display("[TB] imem full lines, partial line, wrap, empty and NOP headers");
    pay.delete();
    for (int i = 1; i <= 8; i++) pay.push_back(32'(32'h11 * i));
    sendImem(0);
    pay.delete();
    for (int i = 1; i <= 6; i++) pay.push_back(32'(32'hA0 + i));
    sendImem(5);
    pay.delete();
    for (int i = 1; i <= 5; i++) pay.push_back(32'(32'hB0 + i));
    sendImem(511);
    pay.delete();
    sendImem(3);
    applyStimulus(32'h0000_0005);
    idle(3);

    $display("[TB] dmem words and index wrap");
    pay.delete();
    for (int i = 1; i <= 3; i++) pay.push_back(32'(9 + i));
    sendDmem(16);
    pay.delete();
    pay.push_back(32'hD1);
    pay.push_back(32'hD2);
    sendDmem(16383);
    idle(2);

    checkOutput("line0_addr", ilogAddrAt(0), 0);
    checkOutput("line0_data", ilogAt(0), 128'h00000011_00000022_00000033_00000044);
    checkOutput("line1_addr", ilogAddrAt(1), 1);
    checkOutput("line1_data", ilogAt(1), 128'h00000055_00000066_00000077_00000088);
    checkOutput("line5_addr", ilogAddrAt(2), 5);
    checkOutput("line5_data", ilogAt(2), 128'h000000A1_000000A2_000000A3_000000A4);
    checkOutput("line6_addr", ilogAddrAt(3), 6);
    checkOutput("line6_data", ilogAt(3), 128'h000000A5_000000A6_00000000_00000000);
    checkOutput("wrap_line_addr", ilogAddrAt(4), 511);
    checkOutput("wrap_next_addr", ilogAddrAt(5), 0);
    checkOutput("wrap_next_data", ilogAt(5), 128'h000000B5_00000000_00000000_00000000);
    checkOutput("imem_write_count", 32'(ilog_data.size()), 6);
    checkOutput("dmem_addr0", dlogAddrAt(0), 32'h40);
    checkOutput("dmem_addr1", dlogAddrAt(1), 32'h44);
    checkOutput("dmem_addr2", dlogAddrAt(2), 32'h48);
    checkOutput("dmem_data2", dlogDataAt(2), 32'hC);
    checkOutput("dmem_wrap_addr0", dlogAddrAt(3), 32'hFFFC);
    checkOutput("dmem_wrap_addr1", dlogAddrAt(4), 32'h0);

    $display("[TB] release and run");
    sendDone(1'b0);
    idle(RST_HOLD + 3);
    checkOutput("release_latency", 32'(fall_cyc - done_cyc), 4);
    checkOutput("loaded_after_release", loaded, 1'b1);
    runCore(20);

    $display("[TB] reset mid-load then reload");
    resetDut();
    applyStimulus(32'h4000_0004);
    applyStimulus(32'h1);
    applyStimulus(32'h2);
    resetDut();
    idle(2);
    pay.delete();
    for (int i = 1; i <= 4; i++) pay.push_back(32'(32'hE0 + i));
    sendImem(0);
    pay.delete();
    pay.push_back(32'h1234_5678);
    sendDmem(2);
    idle(2);
    checkOutput("reload_line_count", 32'(ilog_data.size()), 1);
    checkOutput("reload_line_data", ilogAt(0), 128'h000000E1_000000E2_000000E3_000000E4);
    checkOutput("reload_dmem_addr", dlogAddrAt(0), 32'h8);
    sendDone(1'b0);
    idle(RST_HOLD + 3);
    checkOutput("reload_loaded", loaded, 1'b1);
    runCore(5);

`ifdef PROG_LOADER_CSUM_EN
    $display("[TB] checksum mismatch");
    resetDut();
    pay.delete();
    pay.push_back(32'hFFFF_FFF0);
    pay.push_back(32'h20);
    sendDmem(0);
    sendDone(1'b1);
    runCore(20);
    checkOutput("error_core_reset", core_reset, 1'b1);
    checkOutput("error_in_ready", in_ready, 1'b0);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
